// File: rtl/unidade_de_controle_pkg.sv
// Shared encodings for the control unit: opcodes, FSM states, branch conditions,
// ULA operation codes and datapath mux selects.
package cpu_defs;

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_RTYPE  = 3'b001,
    OP_CONST  = 3'b010,
    OP_MEM    = 3'b011,
    OP_BR_IMM = 3'b100,
    OP_BR_REG = 3'b101,
    OP_RSVD   = 3'b110,
    OP_HALT   = 3'b111
  } opcode_e;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_LOAD_IR  = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC     = 4'd3,
    S_MEM      = 4'd4,
    S_MEM_WAIT = 4'd5,
    S_WB       = 4'd6,
    S_PC_UPD   = 4'd7,
    S_HALT     = 4'd8
  } state_e;

  localparam logic [3:0] COND_ALWAYS = 4'b0000;
  localparam logic [3:0] COND_Z      = 4'b0001;
  localparam logic [3:0] COND_NZ     = 4'b0010;
  localparam logic [3:0] COND_C      = 4'b0011;
  localparam logic [3:0] COND_NC     = 4'b0100;
  localparam logic [3:0] COND_S      = 4'b0101;
  localparam logic [3:0] COND_NS     = 4'b0110;
  localparam logic [3:0] COND_V      = 4'b0111;
  localparam logic [3:0] COND_NV     = 4'b1000;

  // Flag register bit positions, matching the ULA_FLAGS bus order {Z, C, S, V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 0;

  localparam logic [4:0] OPULA_ADD = 5'd0;
  localparam logic [4:0] OPULA_AND = 5'd1;
  localparam logic [4:0] OPULA_OR  = 5'd2;
  localparam logic [4:0] OPULA_XOR = 5'd3;

  localparam logic [1:0] WB_SRC_ULA  = 2'b00;
  localparam logic [1:0] WB_SRC_MEM  = 2'b01;
  localparam logic [1:0] WB_SRC_LINK = 2'b10;

  localparam logic [1:0] PC_SRC_INC = 2'b00;
  localparam logic [1:0] PC_SRC_REL = 2'b01;
  localparam logic [1:0] PC_SRC_REG = 2'b10;

  function automatic logic [4:0] const_opula(input logic [1:0] opes);
    case (opes)
      2'b00:   return OPULA_ADD;
      2'b01:   return OPULA_AND;
      2'b10:   return OPULA_OR;
      default: return OPULA_XOR;
    endcase
  endfunction

endpackage

// File: rtl/unidade_de_controle_if.sv
// Datapath-facing bus of the control unit: instruction/ULA inputs and the
// strobes and mux selects it drives into the datapath.
interface unidade_de_controle_if;
  logic [31:0] MEM_INS_Q;
  logic        ULA_OUT_Ready;
  logic [3:0]  ULA_FLAGS;
  logic [31:0] INSTRUC;
  logic [4:0]  UNIDADE_CONTR_ULA_OPULA;
  logic        ULA_Enable;
  logic        ULA_Src_B;
  logic        B_R_Signal_read;
  logic        B_R_Signal_write;
  logic [1:0]  WB_Src;
  logic        MEM_DATA_WE;
  logic        PC_Signal_write;
  logic [1:0]  PC_Src;

  modport master (
    input  MEM_INS_Q, ULA_OUT_Ready, ULA_FLAGS,
    output INSTRUC, UNIDADE_CONTR_ULA_OPULA, ULA_Enable, ULA_Src_B,
           B_R_Signal_read, B_R_Signal_write, WB_Src,
           MEM_DATA_WE, PC_Signal_write, PC_Src
  );

  modport slave (
    output MEM_INS_Q, ULA_OUT_Ready, ULA_FLAGS,
    input  INSTRUC, UNIDADE_CONTR_ULA_OPULA, ULA_Enable, ULA_Src_B,
           B_R_Signal_read, B_R_Signal_write, WB_Src,
           MEM_DATA_WE, PC_Signal_write, PC_Src
  );
endinterface

// File: rtl/unidade_de_controle_avaliador_de_condicao.sv
// Branch condition evaluator: decides whether a conditional branch is taken
// from its COND field and the latched ULA flags.
module avaliador_de_condicao
  import cpu_defs::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_Z:      taken = flags[FLAG_Z];
      COND_NZ:     taken = !flags[FLAG_Z];
      COND_C:      taken = flags[FLAG_C];
      COND_NC:     taken = !flags[FLAG_C];
      COND_S:      taken = flags[FLAG_S];
      COND_NS:     taken = !flags[FLAG_S];
      COND_V:      taken = flags[FLAG_V];
      COND_NV:     taken = !flags[FLAG_V];
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/unidade_de_controle.sv
// Multi-cycle control unit: walks each instruction through fetch, decode,
// execute, memory and write-back, driving one write strobe at a time.
module unidade_de_controle
  import cpu_defs::*;
#(
  parameter int ULA_TIMEOUT = 15
) (
  input  logic                  Clock_in,
  input  logic                  Reset_n,
  unidade_de_controle_if.master bus,
  output logic                  Halted,
  output logic                  Error,
  output logic [3:0]            State
);

  localparam int CNT_W = $clog2(ULA_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ULA_TIMEOUT - 1);

  state_e           state, next_state;
  logic [31:0]      ir;
  logic [3:0]       flags;
  logic [CNT_W-1:0] wait_cnt;
  logic             error_q;

  opcode_e opcode;
  logic    is_link, is_store, cond_taken;
  logic    ula_done, ula_timeout, latch_flags;

  logic       ula_enable, ula_src_b, br_read, br_write, mem_we, pc_write;
  logic [4:0] opula;
  logic [1:0] wb_src, pc_src;

  assign opcode   = opcode_e'(ir[31:29]);
  assign is_link  = ir[20];
  assign is_store = ir[20];

  assign ula_done    = (state == S_EXEC) && bus.ULA_OUT_Ready;
  assign ula_timeout = (state == S_EXEC) && !bus.ULA_OUT_Ready && (wait_cnt == CNT_LAST);
  assign latch_flags = ula_done && ((opcode == OP_RTYPE) || (opcode == OP_CONST));

  avaliador_de_condicao u_avaliador (
    .cond  (ir[27:24]),
    .flags (flags),
    .taken (cond_taken)
  );

  always_ff @(posedge Clock_in or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_FETCH;
      ir       <= '0;
      flags    <= '0;
      wait_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_LOAD_IR) ir <= bus.MEM_INS_Q;
      if (latch_flags) flags <= bus.ULA_FLAGS;
      // Counter only runs while EXEC waits; any other state rearms it
      if ((state == S_EXEC) && !bus.ULA_OUT_Ready) wait_cnt <= wait_cnt + 1'b1;
      else wait_cnt <= '0;
      if (ula_timeout) error_q <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    ula_enable = 1'b0;
    ula_src_b  = 1'b0;
    br_read    = 1'b0;
    br_write   = 1'b0;
    mem_we     = 1'b0;
    pc_write   = 1'b0;
    opula      = '0;
    wb_src     = WB_SRC_ULA;
    pc_src     = PC_SRC_INC;
    case (state)
      S_FETCH:   next_state = S_LOAD_IR;
      S_LOAD_IR: next_state = S_DECODE;
      S_DECODE: begin
        br_read = 1'b1;
        case (opcode)
          OP_RTYPE, OP_CONST, OP_MEM: next_state = S_EXEC;
          OP_BR_REG: next_state = is_link ? S_WB : S_PC_UPD;
          OP_HALT:   next_state = S_HALT;
          default:   next_state = S_PC_UPD;
        endcase
      end
      S_EXEC: begin
        ula_enable = 1'b1;
        case (opcode)
          OP_RTYPE: opula = ir[4:0];
          OP_CONST: begin
            opula     = const_opula(ir[20:19]);
            ula_src_b = 1'b1;
          end
          default: begin
            opula     = OPULA_ADD;
            ula_src_b = 1'b1;
          end
        endcase
        // A timed-out operation produced nothing to store or write back
        if (bus.ULA_OUT_Ready) next_state = (opcode == OP_MEM) ? S_MEM : S_WB;
        else if (ula_timeout) next_state = S_PC_UPD;
      end
      S_MEM: begin
        if (is_store) begin
          mem_we     = 1'b1;
          next_state = S_PC_UPD;
        end else begin
          next_state = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: next_state = S_WB;
      S_WB: begin
        br_write = 1'b1;
        if (opcode == OP_MEM) wb_src = WB_SRC_MEM;
        else if (opcode == OP_BR_REG) wb_src = WB_SRC_LINK;
        next_state = S_PC_UPD;
      end
      S_PC_UPD: begin
        pc_write = 1'b1;
        if ((opcode == OP_BR_IMM) && (ir[28] || cond_taken)) pc_src = PC_SRC_REL;
        else if (opcode == OP_BR_REG) pc_src = PC_SRC_REG;
        next_state = S_FETCH;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
  end

  assign bus.INSTRUC                 = ir;
  assign bus.UNIDADE_CONTR_ULA_OPULA = opula;
  assign bus.ULA_Enable              = ula_enable;
  assign bus.ULA_Src_B               = ula_src_b;
  assign bus.B_R_Signal_read         = br_read;
  assign bus.B_R_Signal_write        = br_write;
  assign bus.WB_Src                  = wb_src;
  assign bus.MEM_DATA_WE             = mem_we;
  assign bus.PC_Signal_write         = pc_write;
  assign bus.PC_Src                  = pc_src;

  assign Halted = (state == S_HALT);
  assign Error  = error_q;
  assign State  = state;

endmodule

// File: tb/tb_unidade_de_controle.sv
// Bench for unidade_de_controle: directed vector table, randomized instructions
// against a cycle-count reference model, HALT hold and reset mid-write-back.
module tb_unidade_de_controle;
  import cpu_defs::*;

  localparam int TMO  = 15;
  localparam int MAXC = 60;

  logic       Clock_in;
  logic       Reset_n;
  logic       Halted;
  logic       Error;
  logic [3:0] State;

  unidade_de_controle_if bus ();

  unidade_de_controle #(.ULA_TIMEOUT(TMO)) dut (
    .Clock_in (Clock_in),
    .Reset_n  (Reset_n),
    .bus      (bus),
    .Halted   (Halted),
    .Error    (Error),
    .State    (State)
  );

  initial Clock_in = 1'b0;
  always #5 Clock_in = ~Clock_in;

  typedef struct {
    int len; int brw_cyc; int we_cyc; int en_n;
    int pc_src; int wb_src; int opula; int srcb; int err; int halt;
  } exp_t;

  typedef struct {
    int len; int brw_cyc; int brw_n; int we_cyc; int we_n; int en_n;
    int rd_cyc; int overlap; int pc_src; int wb_src; int opula; int srcb;
    int halt; logic [31:0] ir;
  } obs_t;

  typedef struct {
    logic [31:0] ins; int dly; logic [3:0] fl;
    int len; int brw; int we; int pc; int wb; int err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [3:0] m_flags;
  logic       m_err;
  logic [4:0] opes_tbl [4] = '{OPULA_ADD, OPULA_AND, OPULA_OR, OPULA_XOR};
  vec_t tbl [18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({bus.UNIDADE_CONTR_ULA_OPULA, bus.ULA_Enable, bus.ULA_Src_B,
                 bus.B_R_Signal_read, bus.B_R_Signal_write, bus.WB_Src,
                 bus.MEM_DATA_WE, bus.PC_Signal_write, bus.PC_Src});
  endfunction

  function automatic int strobes();
    return int'({bus.B_R_Signal_write, bus.MEM_DATA_WE, bus.PC_Signal_write});
  endfunction

  // Condition codes come in (flag, !flag) pairs over Z, C, S, V after ALWAYS
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    int k;
    if (c == 4'd0) return 1'b1;
    if (c > 4'd8) return 1'b0;
    k = int'(c) - 1;
    return (k % 2 == 0) ? f[3 - k / 2] : !f[3 - k / 2];
  endfunction

  task automatic ref_model(input logic [31:0] ins, input int dly, input logic [3:0] fl,
                           output exp_t e);
    int op;
    bit ula, tmo;
    int t;
    e  = '{default: 0};
    op = int'(ins[31:29]);
    if (op == 7) begin
      e.len  = 4;
      e.halt = 1;
      e.err  = int'(m_err);
      return;
    end
    ula = (op >= 1) && (op <= 3);
    tmo = ula && (dly >= TMO);
    t   = 3;
    if (ula) begin
      e.en_n  = tmo ? TMO : dly + 1;
      t      += e.en_n;
      e.opula = (op == 1) ? int'(ins[4:0]) :
                (op == 2) ? int'(opes_tbl[ins[20:19]]) : int'(OPULA_ADD);
      e.srcb  = (op == 1) ? 0 : 1;
    end
    if (!tmo) begin
      if (op == 3) begin
        t++;
        if (ins[20]) e.we_cyc = t;
        else begin t += 2; e.brw_cyc = t; e.wb_src = 1; end
      end else if (op == 1 || op == 2) begin
        t++; e.brw_cyc = t;
      end else if (op == 5 && ins[20]) begin
        t++; e.brw_cyc = t; e.wb_src = 2;
      end
    end
    t++;
    e.len = t;
    if (op == 4) e.pc_src = (ins[28] || cond_ok(ins[27:24], m_flags)) ? 1 : 0;
    else if (op == 5) e.pc_src = 2;
    if (tmo) m_err = 1'b1;
    if ((op == 1 || op == 2) && !tmo) m_flags = fl;
    e.err = int'(m_err);
  endtask

  // Starts on the negedge of a FETCH cycle (cycle 1) and returns on the
  // negedge of the following FETCH; ready is given on EXEC cycle dly+1.
  task automatic run_instr(input logic [31:0] ins, input int dly, input logic [3:0] fl,
                           output obs_t o);
    bit done;
    o = '{default: 0};
    bus.MEM_INS_Q     = ins;
    bus.ULA_FLAGS     = fl;
    bus.ULA_OUT_Ready = 1'b0;
    for (int c = 1; c <= MAXC; c++) begin
      if (bus.ULA_Enable) begin
        if (o.en_n == 0) begin
          o.opula = int'(bus.UNIDADE_CONTR_ULA_OPULA);
          o.srcb  = int'(bus.ULA_Src_B);
        end
        bus.ULA_OUT_Ready = (o.en_n == dly);
        o.en_n++;
      end else begin
        bus.ULA_OUT_Ready = 1'b0;
      end
      if (bus.B_R_Signal_read) o.rd_cyc = c;
      if (bus.B_R_Signal_write) begin o.brw_cyc = c; o.brw_n++; o.wb_src = int'(bus.WB_Src); end
      if (bus.MEM_DATA_WE) begin o.we_cyc = c; o.we_n++; end
      if ((int'(bus.B_R_Signal_write) + int'(bus.MEM_DATA_WE) + int'(bus.PC_Signal_write)) > 1)
        o.overlap++;
      if (bus.PC_Signal_write) begin o.pc_src = int'(bus.PC_Src); o.len = c; end
      if (Halted) begin o.halt = 1; o.len = c; end
      if (c == 3) o.ir = bus.INSTRUC;
      done = bus.PC_Signal_write || Halted;
      @(negedge Clock_in);
      if (done) break;
    end
    bus.ULA_OUT_Ready = 1'b0;
  endtask

  task automatic compare_full(input string tag, input logic [31:0] ins, input exp_t e,
                              input obs_t o);
    chk({tag, "_len"},     o.len,     e.len);
    chk({tag, "_brw_cyc"}, o.brw_cyc, e.brw_cyc);
    chk({tag, "_brw_n"},   o.brw_n,   (e.brw_cyc != 0) ? 1 : 0);
    chk({tag, "_we_cyc"},  o.we_cyc,  e.we_cyc);
    chk({tag, "_we_n"},    o.we_n,    (e.we_cyc != 0) ? 1 : 0);
    chk({tag, "_en_n"},    o.en_n,    e.en_n);
    chk({tag, "_pc_src"},  o.pc_src,  e.pc_src);
    chk({tag, "_wb_src"},  o.wb_src,  e.wb_src);
    chk({tag, "_rd_cyc"},  o.rd_cyc,  3);
    chk({tag, "_overlap"}, o.overlap, 0);
    chk({tag, "_ir"},      int'(o.ir), int'(ins));
    chk({tag, "_error"},   int'(Error), e.err);
    chk({tag, "_halt"},    o.halt,    e.halt);
    if (e.en_n > 0) begin
      chk({tag, "_opula"}, o.opula, e.opula);
      chk({tag, "_srcb"},  o.srcb,  e.srcb);
    end
  endtask

  task automatic do_reset();
    bus.MEM_INS_Q     = '0;
    bus.ULA_FLAGS     = '0;
    bus.ULA_OUT_Ready = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk("rst_state", int'(State), 0);
    chk("rst_outs", outs(), 0);
    chk("rst_ir", int'(bus.INSTRUC), 0);
    chk("rst_error", int'(Error), 0);
    chk("rst_halted", int'(Halted), 0);
    repeat (2) @(negedge Clock_in);
    Reset_n = 1'b1;
    m_flags = '0;
    m_err   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    obs_t        o;
    exp_t        e;
    logic [31:0] ins;
    logic [3:0]  fl;
    logic [2:0]  op;
    int          dly, bad;

    //          ins           dly fl       len brw we pc wb err
    tbl[0]  = '{32'h2000_0003, 0, 4'b1000, 6, 5, 0, 0, 0, 0};
    tbl[1]  = '{32'h8200_0010, 0, 4'b0000, 4, 0, 0, 0, 0, 0};
    tbl[2]  = '{32'h8100_0010, 0, 4'b0000, 4, 0, 0, 1, 0, 0};
    tbl[3]  = '{32'h8F00_0010, 0, 4'b0000, 4, 0, 0, 0, 0, 0};
    tbl[4]  = '{32'h9F00_0010, 0, 4'b0000, 4, 0, 0, 1, 0, 0};
    tbl[5]  = '{32'h6000_0004, 0, 4'b0111, 8, 7, 0, 0, 1, 0};
    tbl[6]  = '{32'h8100_0000, 0, 4'b0000, 4, 0, 0, 1, 0, 0};
    tbl[7]  = '{32'h6010_0004, 1, 4'b0000, 7, 0, 6, 0, 0, 0};
    tbl[8]  = '{32'h2000_0001, 99, 4'b0000, 19, 0, 0, 0, 0, 1};
    tbl[9]  = '{32'h8100_0000, 0, 4'b0000, 4, 0, 0, 1, 0, 1};
    tbl[10] = '{32'hA010_0000, 0, 4'b0000, 5, 4, 0, 2, 2, 1};
    tbl[11] = '{32'hA000_0000, 0, 4'b0000, 4, 0, 0, 2, 0, 1};
    tbl[12] = '{32'h0000_0000, 0, 4'b0000, 4, 0, 0, 0, 0, 1};
    tbl[13] = '{32'hC000_0000, 0, 4'b0000, 4, 0, 0, 0, 0, 1};
    tbl[14] = '{32'h4010_0000, 2, 4'b0100, 8, 7, 0, 0, 0, 1};
    tbl[15] = '{32'h8300_0000, 0, 4'b0000, 4, 0, 0, 1, 0, 1};
    tbl[16] = '{32'h8200_0000, 0, 4'b0000, 4, 0, 0, 1, 0, 1};
    tbl[17] = '{32'h8100_0000, 0, 4'b0000, 4, 0, 0, 0, 0, 1};

    Reset_n = 1'b1;
    bus.MEM_INS_Q = '0;
    bus.ULA_FLAGS = '0;
    bus.ULA_OUT_Ready = 1'b0;
    #3;
    do_reset();

    for (int i = 0; i < 18; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_instr(tbl[i].ins, tbl[i].dly, tbl[i].fl, o);
      chk({tag, "_len"},     o.len,     tbl[i].len);
      chk({tag, "_brw_cyc"}, o.brw_cyc, tbl[i].brw);
      chk({tag, "_brw_n"},   o.brw_n,   (tbl[i].brw != 0) ? 1 : 0);
      chk({tag, "_we_cyc"},  o.we_cyc,  tbl[i].we);
      chk({tag, "_pc_src"},  o.pc_src,  tbl[i].pc);
      chk({tag, "_wb_src"},  o.wb_src,  tbl[i].wb);
      chk({tag, "_overlap"}, o.overlap, 0);
      chk({tag, "_error"},   int'(Error), tbl[i].err);
    end

    do_reset();
    for (int n = 0; n < 40; n++) begin
      op  = 3'($urandom_range(0, 6));
      ins = $urandom;
      ins[31:29] = op;
      fl  = 4'($urandom);
      dly = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
      ref_model(ins, dly, fl, e);
      run_instr(ins, dly, fl, o);
      compare_full($sformatf("rnd%0d", n), ins, e, o);
    end

    ref_model(32'hE000_0000, 0, 4'b0000, e);
    run_instr(32'hE000_0000, 0, 4'b0000, o);
    compare_full("halt", 32'hE000_0000, e, o);
    bad = 0;
    repeat (50) begin
      if (strobes() != 0 || bus.ULA_Enable || bus.B_R_Signal_read || !Halted) bad++;
      @(negedge Clock_in);
    end
    chk("halt_hold_bad_cycles", bad, 0);

    do_reset();
    bus.MEM_INS_Q     = 32'h2000_0005;
    bus.ULA_FLAGS     = 4'b0000;
    bus.ULA_OUT_Ready = 1'b1;
    repeat (4) @(negedge Clock_in);
    chk("midwb_reached_wb", int'(bus.B_R_Signal_write), 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("midwb_outs", outs(), 0);
    chk("midwb_state", int'(State), 0);
    bad = 0;
    repeat (3) begin
      @(negedge Clock_in);
      if (strobes() != 0) bad++;
    end
    chk("midwb_strobes_in_reset", bad, 0);
    bus.ULA_OUT_Ready = 1'b0;
    Reset_n = 1'b1;
    m_flags = '0;
    m_err   = 1'b0;
    ref_model(32'h0000_0000, 0, 4'b0000, e);
    run_instr(32'h0000_0000, 0, 4'b0000, o);
    compare_full("resume_nop", 32'h0000_0000, e, o);
    ref_model(32'h8100_0000, 0, 4'b0000, e);
    run_instr(32'h8100_0000, 0, 4'b0000, o);
    compare_full("resume_brz", 32'h8100_0000, e, o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidade_de_controle.md
UNIDADE_DE_CONTROLE -- requirements
Module: unidade_de_controle

Interface
REQ-001 SHALL have parameter ULA_TIMEOUT, default 15, the maximum number of cycles spent waiting for ULA_OUT_Ready.
REQ-002 SHALL have ports: Clock_in  in  1  single system clock, rising edge.
REQ-003 SHALL have ports: Reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: MEM_INS_Q  in  32  instruction word from the synchronous instruction memory; ULA_OUT_Ready  in  1  ULA result valid.
REQ-005 SHALL have ports: ULA_FLAGS  in  4  {Zero, Carry_out, Signal, Overflow} from the ULA.
REQ-006 SHALL have ports: INSTRUC  out  32  latched instruction register (IR); UNIDADE_CONTR_ULA_OPULA  out  5  ULA operation code.
REQ-007 SHALL have ports: ULA_Enable  out  1; ULA_Src_B  out  1  (0 = register B, 1 = sign-extended immediate).
REQ-008 SHALL have ports: B_R_Signal_read  out  1; B_R_Signal_write  out  1; WB_Src  out  2  (00 ULA_OUT, 01 MEM_DATA_Q, 10 PC+1).
REQ-009 SHALL have ports: MEM_DATA_WE  out  1; PC_Signal_write  out  1; PC_Src  out  2  (00 PC+1, 01 PC+1+imm, 10 register RA).
REQ-010 SHALL have ports: Halted  out  1; Error  out  1  sticky ULA timeout; State  out  4  debug state code.

Function
REQ-011 Instruction layout SHALL be: [31:29] opcode; [28:25] WC; [24:21] RA; [20:17] RB; [4:0] OPULA; [20:19] OPES; [20] OPM (0 load, 1 store) or OPD (1 = link); [15:0] immediate.
REQ-012 Branch layout (opcode 100) SHALL be: [28] OP (1 unconditional); [27:24] COND; [15:0] offset.
REQ-013 Opcodes SHALL be: 000 NOP, 001 R-type, 010 constant, 011 memory, 100 branch immediate, 101 branch register, 110 reserved (executed as NOP), 111 HALT.
REQ-014 States SHALL be: FETCH, LOAD_IR, DECODE, EXEC, MEM, MEM_WAIT, WB, PC_UPD, HALT.
REQ-015 State sequence: FETCH -> LOAD_IR (IR <= MEM_INS_Q on this edge) -> DECODE (B_R_Signal_read = 1).
REQ-016 From DECODE: opcodes 001/010/011 -> EXEC; 101 with OPD=1 -> WB; 111 -> HALT; all others -> PC_UPD.
REQ-017 EXEC SHALL hold ULA_Enable = 1 until ULA_OUT_Ready is seen, then go to WB (001/010) or MEM (011).
REQ-018 EXEC SHALL maintain a wait counter; if ULA_OUT_Ready is still absent after ULA_TIMEOUT cycles, it SHALL set Error, skip WB and MEM, and go to PC_UPD.
REQ-019 UNIDADE_CONTR_ULA_OPULA mapping: R-type = IR[4:0]; constant: OPES 00/01/10/11 = OPULA_ADD/AND/OR/XOR; memory = OPULA_ADD with ULA_Src_B = 1.
REQ-020 The flag register SHALL latch ULA_FLAGS only on the EXEC cycle in which ULA_OUT_Ready = 1 for opcodes 001 and 010.
REQ-021 MEM: store asserts MEM_DATA_WE = 1 for exactly one cycle, then PC_UPD; load goes to MEM_WAIT and then WB with WB_Src = 01.
REQ-022 WB SHALL assert B_R_Signal_write for exactly one cycle, then PC_UPD; for a link (101, OPD=1) WB_Src SHALL be 10.
REQ-023 PC_UPD SHALL assert PC_Signal_write for exactly one cycle, then FETCH; PC_Src SHALL be 01 for a taken 100, 10 for 101, and 00 otherwise.
REQ-024 COND codes: 0000 always; 0001 Z; 0010 !Z; 0011 C; 0100 !C; 0101 S; 0110 !S; 0111 V; 1000 !V; 1001-1111 never taken. Conditions SHALL be evaluated on the latched flags.
REQ-025 Latencies (ULA ready on first EXEC cycle): NOP/branch 4 cycles; R-type/constant 6; store 6; load 8; branch register with link 5.
REQ-026 HALT SHALL be absorbing with Halted = 1 and all strobes 0 until reset.
REQ-027 Write strobes (B_R_Signal_write, MEM_DATA_WE, PC_Signal_write) SHALL be mutually exclusive and at most one cycle each per instruction.

Reset
REQ-028 Reset_n low SHALL asynchronously force state FETCH, and IR, flags, wait counter, Error, Halted and all outputs to 0.
REQ-029 Reset asserted mid-instruction SHALL abort that instruction with no further write strobe.
REQ-030 The first FETCH SHALL occur on the first rising edge after Reset_n deasserts.

Structure
REQ-031 Package cpu_defs SHALL hold the opcode values, state encodings, COND codes, OPULA_ADD/AND/OR/XOR, and the WB_Src/PC_Src encodings.
REQ-032 Condition evaluation SHALL be a combinational sub-module avaliador_de_condicao (COND, flags -> taken).

Verification
REQ-033 R-type 0x2000_0000-class word, ULA ready on first EXEC cycle, flags 4'b1000 -> B_R_Signal_write at cycle 5, PC_Signal_write at cycle 6 with PC_Src=00, Z latched.
REQ-034 Load (opcode 011, OPM=0) -> MEM_DATA_WE never 1; WB_Src=01 in WB; PC_Signal_write at cycle 8.
REQ-035 Z=1 latched, then branch COND=0010 -> PC_Src=00; same branch with COND=0001 -> PC_Src=01; COND=1111 -> PC_Src=00.
REQ-036 ULA_OUT_Ready held 0 -> Error=1 after 15 EXEC cycles, no B_R_Signal_write, PC_Signal_write one cycle later.
REQ-037 Opcode 111 -> Halted=1, no strobes for 50 cycles; Reset_n pulse mid-WB -> no write strobe, outputs 0, FETCH resumes after release.
